// File: rtl/cellrv32_bus_gateway.sv
// cellrv32_bus_gateway: responder-side gateway of the CPU/switch bus.
// Decodes one access at a time into IMEM, DMEM or IO and returns the
// selected target's response; raises its own error on unmapped
// addresses, user-mode IO accesses and response timeouts.
//
// Ports:
//   clk_i, rstn_i        clock (rising edge), async active-low reset
//   h_*                  upstream initiator request / response
//   t_*                  shared target bus (combinational copies of h_*)
//   im_*, dm_*, io_*     per-target strobes and responses
//   busy_o               access outstanding (state != IDLE)
//   tmo_o                one-cycle pulse in the ERR cycle of a timeout
module cellrv32_bus_gateway #(
    parameter logic [31:0] IMEM_BASE  = 32'h0000_0000,
    parameter int          IMEM_SIZE  = 16384,
    parameter logic [31:0] DMEM_BASE  = 32'h8000_0000,
    parameter int          DMEM_SIZE  = 8192,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FE00,
    parameter int          IO_SIZE    = 512,
    parameter int          TMO_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    // upstream initiator
    input  logic        h_priv_i,
    input  logic        h_src_i,
    input  logic [31:0] h_addr_i,
    input  logic [31:0] h_wdata_i,
    input  logic [3:0]  h_ben_i,
    input  logic        h_we_i,
    input  logic        h_re_i,
    output logic [31:0] h_rdata_o,
    output logic        h_ack_o,
    output logic        h_err_o,
    // shared target bus
    output logic [31:0] t_addr_o,
    output logic [31:0] t_wdata_o,
    output logic [3:0]  t_ben_o,
    output logic        t_priv_o,
    output logic        t_src_o,
    // per-target strobes
    output logic        im_re_o,
    output logic        im_we_o,
    output logic        dm_re_o,
    output logic        dm_we_o,
    output logic        io_re_o,
    output logic        io_we_o,
    // target responses
    input  logic [31:0] im_rdata_i,
    input  logic [31:0] dm_rdata_i,
    input  logic [31:0] io_rdata_i,
    input  logic        im_ack_i,
    input  logic        dm_ack_i,
    input  logic        io_ack_i,
    input  logic        im_err_i,
    input  logic        dm_err_i,
    input  logic        io_err_i,
    // status
    output logic        busy_o,
    output logic        tmo_o
);

    localparam logic [31:0] IM_MASK  = ~(32'(IMEM_SIZE) - 32'd1);
    localparam logic [31:0] DM_MASK  = ~(32'(DMEM_SIZE) - 32'd1);
    localparam logic [31:0] IO_MASK  = ~(32'(IO_SIZE) - 32'd1);
    localparam logic [9:0]  TMO_LAST = 10'(TMO_CYCLES - 1);
    localparam logic [9:0]  CNT_MAX  = 10'h3FF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_IM,
        SEL_DM,
        SEL_IO
    } sel_t;

    state_t      r_state;
    state_t      w_state_nxt;
    sel_t        r_sel;
    sel_t        w_sel_nxt;
    logic [9:0]  r_cnt;
    logic [9:0]  w_cnt_nxt;
    logic        r_tmo;
    logic        w_tmo_nxt;

    logic        w_hit_im;
    logic        w_hit_dm;
    logic        w_hit_io;
    sel_t        w_dec;
    logic        w_req;
    logic        w_grant;
    logic        w_fwd;

    logic        w_rsp_ack;
    logic        w_rsp_err;
    logic [31:0] w_rsp_rdata;

    // shared target bus
    assign t_addr_o  = h_addr_i;
    assign t_wdata_o = h_wdata_i;
    assign t_ben_o   = h_ben_i;
    assign t_priv_o  = h_priv_i;
    assign t_src_o   = h_src_i;

    // address decode
    assign w_hit_im = (h_addr_i & IM_MASK) == IMEM_BASE;
    assign w_hit_dm = (h_addr_i & DM_MASK) == DMEM_BASE;
    assign w_hit_io = (h_addr_i & IO_MASK) == IO_BASE;

    // overlapping regions resolve IO > DMEM > IMEM
    always_comb begin
        w_dec = SEL_NONE;
        if (w_hit_io) begin
            w_dec = SEL_IO;
        end else if (w_hit_dm) begin
            w_dec = SEL_DM;
        end else if (w_hit_im) begin
            w_dec = SEL_IM;
        end
    end

    assign w_req   = h_re_i | h_we_i;
    assign w_grant = (w_dec != SEL_NONE) &&
                     ((w_dec != SEL_IO) || h_priv_i);
    // strobes only pass in IDLE; anything during BUSY/ERR is dropped
    assign w_fwd   = (r_state == S_IDLE) && w_req && w_grant;

    assign im_re_o = w_fwd && (w_dec == SEL_IM) && h_re_i;
    assign im_we_o = w_fwd && (w_dec == SEL_IM) && h_we_i;
    assign dm_re_o = w_fwd && (w_dec == SEL_DM) && h_re_i;
    assign dm_we_o = w_fwd && (w_dec == SEL_DM) && h_we_i;
    assign io_re_o = w_fwd && (w_dec == SEL_IO) && h_re_i;
    assign io_we_o = w_fwd && (w_dec == SEL_IO) && h_we_i;

    // only the latched target is listened to
    always_comb begin
        w_rsp_ack   = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = 32'h0;
        unique case (r_sel)
            SEL_IM: begin
                w_rsp_ack   = im_ack_i;
                w_rsp_err   = im_err_i;
                w_rsp_rdata = im_rdata_i;
            end
            SEL_DM: begin
                w_rsp_ack   = dm_ack_i;
                w_rsp_err   = dm_err_i;
                w_rsp_rdata = dm_rdata_i;
            end
            SEL_IO: begin
                w_rsp_ack   = io_ack_i;
                w_rsp_err   = io_err_i;
                w_rsp_rdata = io_rdata_i;
            end
            default: begin
                w_rsp_ack   = 1'b0;
                w_rsp_err   = 1'b0;
                w_rsp_rdata = 32'h0;
            end
        endcase
    end

    // next-state and response logic
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = 1'b0;
        h_ack_o     = 1'b0;
        h_err_o     = 1'b0;
        h_rdata_o   = 32'h0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_grant) begin
                        w_state_nxt = S_BUSY;
                        w_sel_nxt   = w_dec;
                        w_cnt_nxt   = 10'd0;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_sel_nxt   = SEL_NONE;
                    end
                end
            end
            S_BUSY: begin
                if (w_rsp_err) begin
                    // error wins over a simultaneous ack
                    h_err_o     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_sel_nxt   = SEL_NONE;
                end else if (w_rsp_ack) begin
                    h_ack_o     = 1'b1;
                    h_rdata_o   = w_rsp_rdata;
                    w_state_nxt = S_IDLE;
                    w_sel_nxt   = SEL_NONE;
                end else if (r_cnt >= TMO_LAST) begin
                    // r_cnt counts silent BUSY cycles minus one
                    w_state_nxt = S_ERR;
                    w_sel_nxt   = SEL_NONE;
                    w_tmo_nxt   = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            S_ERR: begin
                h_err_o     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = SEL_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_sel   <= SEL_NONE;
            r_cnt   <= 10'd0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    assign busy_o = (r_state != S_IDLE);
    // r_tmo is only ever set on the transition into ERR
    assign tmo_o  = r_tmo;

endmodule

// File: tb/tb_cellrv32_bus_gateway.sv
// Directed testbench for cellrv32_bus_gateway.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_cellrv32_bus_gateway;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        h_priv, h_src, h_we, h_re;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_ben;
    logic [31:0] h_rdata;
    logic        h_ack, h_err;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_ben;
    logic        t_priv, t_src;
    logic        im_re, im_we, dm_re, dm_we, io_re, io_we;
    logic [31:0] im_rdata, dm_rdata, io_rdata;
    logic        im_ack, dm_ack, io_ack, im_err, dm_err, io_err;
    logic        busy, tmo;

    int n_tests = 0;
    int n_fail  = 0;
    logic seen;

    always #5 clk = ~clk;

    cellrv32_bus_gateway dut (
        .clk_i(clk), .rstn_i(rstn),
        .h_priv_i(h_priv), .h_src_i(h_src), .h_addr_i(h_addr),
        .h_wdata_i(h_wdata), .h_ben_i(h_ben), .h_we_i(h_we), .h_re_i(h_re),
        .h_rdata_o(h_rdata), .h_ack_o(h_ack), .h_err_o(h_err),
        .t_addr_o(t_addr), .t_wdata_o(t_wdata), .t_ben_o(t_ben),
        .t_priv_o(t_priv), .t_src_o(t_src),
        .im_re_o(im_re), .im_we_o(im_we), .dm_re_o(dm_re), .dm_we_o(dm_we),
        .io_re_o(io_re), .io_we_o(io_we),
        .im_rdata_i(im_rdata), .dm_rdata_i(dm_rdata), .io_rdata_i(io_rdata),
        .im_ack_i(im_ack), .dm_ack_i(dm_ack), .io_ack_i(io_ack),
        .im_err_i(im_err), .dm_err_i(dm_err), .io_err_i(io_err),
        .busy_o(busy), .tmo_o(tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [5:0] strobes();
        return {im_re, im_we, dm_re, dm_we, io_re, io_we};
    endfunction

    function automatic logic [2:0] rsp();
        return {busy, h_ack, h_err};
    endfunction

    initial begin
        h_priv = 1'b1; h_src = 1'b0; h_we = 1'b0; h_re = 1'b0;
        h_addr = 32'h1234_5678; h_wdata = 32'h0; h_ben = 4'hF;
        im_rdata = 32'h0; dm_rdata = 32'h0; io_rdata = 32'h0;
        im_ack = 0; dm_ack = 0; io_ack = 0;
        im_err = 0; dm_err = 0; io_err = 0;

        // reset state
        smp();
        chk("rst_rsp", {29'd0, rsp()}, 32'd0);
        chk("rst_tmo", {31'd0, tmo}, 32'd0);
        chk("rst_rdata", h_rdata, 32'd0);
        chk("rst_t_addr", t_addr, 32'h1234_5678);
        nxt();
        rstn = 1'b1;

        // IMEM read, ack one cycle later
        nxt();
        h_addr = 32'h0000_0010; h_re = 1'b1;
        smp();
        chk("im_rd_strobe", {26'd0, strobes()}, 32'h20);
        chk("im_rd_busy_c0", {31'd0, busy}, 32'd0);
        nxt();
        h_re = 1'b0; im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
        smp();
        chk("im_rd_rsp", {29'd0, rsp()}, 32'b110);
        chk("im_rd_data", h_rdata, 32'hDEAD_BEEF);
        chk("im_rd_no_str", {26'd0, strobes()}, 32'd0);
        nxt();
        im_ack = 1'b0;
        smp();
        chk("im_rd_idle", {29'd0, rsp()}, 32'd0);

        // DMEM write, ack at c0+3
        nxt();
        h_addr = 32'h8000_0004; h_we = 1'b1; h_ben = 4'b0011;
        h_wdata = 32'hCAFE_0001;
        smp();
        chk("dm_wr_strobe", {26'd0, strobes()}, 32'h04);
        chk("dm_wr_ben", {28'd0, t_ben}, 32'h3);
        chk("dm_wr_wdata", t_wdata, 32'hCAFE_0001);
        nxt();
        h_we = 1'b0;
        smp();
        chk("dm_wr_c1", {29'd0, rsp()}, 32'b100);
        nxt();
        smp();
        chk("dm_wr_c2", {29'd0, rsp()}, 32'b100);
        nxt();
        dm_ack = 1'b1;
        smp();
        chk("dm_wr_c3", {29'd0, rsp()}, 32'b110);
        nxt();
        dm_ack = 1'b0;
        smp();
        chk("dm_wr_c4", {29'd0, rsp()}, 32'd0);

        // unmapped read
        nxt();
        h_addr = 32'h4000_0000; h_re = 1'b1; h_ben = 4'hF;
        smp();
        chk("unm_strobe", {26'd0, strobes()}, 32'd0);
        nxt();
        h_re = 1'b0;
        smp();
        chk("unm_c1", {29'd0, rsp()}, 32'b101);
        chk("unm_tmo", {31'd0, tmo}, 32'd0);
        nxt();
        smp();
        chk("unm_c2", {29'd0, rsp()}, 32'd0);

        // user-mode IO write is refused
        nxt();
        h_addr = 32'hFFFF_FE08; h_we = 1'b1; h_priv = 1'b0;
        smp();
        chk("io_user_strobe", {26'd0, strobes()}, 32'd0);
        nxt();
        h_we = 1'b0;
        smp();
        chk("io_user_c1", {29'd0, rsp()}, 32'b101);
        nxt();
        // machine-mode IO write is forwarded
        h_we = 1'b1; h_priv = 1'b1;
        smp();
        chk("io_mach_strobe", {26'd0, strobes()}, 32'h01);
        nxt();
        h_we = 1'b0; io_ack = 1'b1;
        smp();
        chk("io_mach_c1", {29'd0, rsp()}, 32'b110);
        nxt();
        io_ack = 1'b0;

        // DMEM read timeout
        nxt();
        h_addr = 32'h8000_0100; h_re = 1'b1;
        smp();
        chk("tmo_strobe", {26'd0, strobes()}, 32'h08);
        seen = 1'b0;
        nxt();
        h_re = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            smp();
            if (h_ack || h_err || tmo || !busy) seen = 1'b1;
            nxt();
        end
        // now at c0+256
        smp();
        chk("tmo_quiet", {31'd0, seen}, 32'd0);
        chk("tmo_err", {29'd0, rsp()}, 32'b101);
        chk("tmo_pulse", {31'd0, tmo}, 32'd1);
        nxt();
        smp();
        chk("tmo_after", {28'd0, rsp(), tmo}, 32'd0);
        nxt();
        nxt();
        nxt();
        dm_ack = 1'b1; dm_rdata = 32'h5555_AAAA;
        smp();
        chk("late_ack", {29'd0, rsp()}, 32'd0);
        nxt();
        dm_ack = 1'b0;
        h_addr = 32'h0000_0020; h_re = 1'b1;
        smp();
        chk("post_tmo_str", {26'd0, strobes()}, 32'h20);
        nxt();
        h_re = 1'b0; im_ack = 1'b1; im_rdata = 32'h0BAD_F00D;
        smp();
        chk("post_tmo_rsp", {29'd0, rsp()}, 32'b110);
        chk("post_tmo_data", h_rdata, 32'h0BAD_F00D);
        nxt();
        im_ack = 1'b0;

        // ack and err together
        nxt();
        h_addr = 32'h0000_0030; h_re = 1'b1;
        nxt();
        h_re = 1'b0; im_ack = 1'b1; im_err = 1'b1;
        im_rdata = 32'h1111_2222;
        smp();
        chk("ackerr_rsp", {29'd0, rsp()}, 32'b101);
        chk("ackerr_data", h_rdata, 32'd0);
        nxt();
        im_ack = 1'b0; im_err = 1'b0;

        // foreign ack while IMEM selected
        nxt();
        h_addr = 32'h0000_0040; h_re = 1'b1;
        nxt();
        h_re = 1'b0; dm_ack = 1'b1; dm_err = 1'b1;
        smp();
        chk("foreign_ack", {29'd0, rsp()}, 32'b100);
        nxt();
        dm_ack = 1'b0; dm_err = 1'b0;
        im_ack = 1'b1; im_rdata = 32'h7777_8888;
        smp();
        chk("own_ack", {29'd0, rsp()}, 32'b110);
        chk("own_data", h_rdata, 32'h7777_8888);
        nxt();
        im_ack = 1'b0;

        // reset during BUSY
        nxt();
        h_addr = 32'h8000_0008; h_re = 1'b1;
        nxt();
        h_re = 1'b0;
        smp();
        chk("rstbusy_pre", {29'd0, rsp()}, 32'b100);
        nxt();
        rstn = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h9999_9999;
        #1;
        chk("rstbusy_rsp", {29'd0, rsp()}, 32'd0);
        chk("rstbusy_data", h_rdata, 32'd0);
        nxt();
        rstn = 1'b1; dm_ack = 1'b0;
        smp();
        chk("rstbusy_after", {28'd0, rsp(), tmo}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cellrv32_bus_gateway.md
Name: cellrv32_bus_gateway

Overview:
Responder-side fabric at the peripheral-bus end of the CPU/switch bus. It accepts one access at a time from the single upstream initiator (priv, src, addr, wdata, ben, we, re / rdata, ack, err). It decodes the address into one of three target regions (IMEM, DMEM, IO), forwards the strobes, and returns the selected target's response. The gateway itself raises a bus error for unmapped addresses, for user-mode IO accesses, and for targets that do not answer within a bounded timeout.

Parameters:
IMEM_BASE, 32'h00000000, IMEM region base; aligned to IMEM_SIZE
IMEM_SIZE, 16384, IMEM region size in bytes; power of two, at least 4
DMEM_BASE, 32'h80000000, DMEM region base; aligned to DMEM_SIZE
DMEM_SIZE, 8192, DMEM region size in bytes; power of two, at least 4
IO_BASE, 32'hFFFFFE00, IO region base; aligned to IO_SIZE
IO_SIZE, 512, IO region size in bytes; power of two, at least 4
TMO_CYCLES, 255, response window in cycles; range 1..1023

Ports:
clk_i  in  1  global clock, rising edge
rstn_i  in  1  global reset, asynchronous, active-low
h_priv_i  in  1  privilege of the access: 1 = machine, 0 = user
h_src_i  in  1  access source tag, forwarded unchanged
h_addr_i  in  32  access address
h_wdata_i  in  32  write data
h_ben_i  in  4  byte enables
h_we_i  in  1  write strobe, single-cycle
h_re_i  in  1  read strobe, single-cycle
h_rdata_o  out  32  read data; zero unless h_ack_o
h_ack_o  out  1  transfer acknowledge, single-cycle
h_err_o  out  1  transfer error, single-cycle
t_addr_o / t_wdata_o / t_ben_o / t_priv_o / t_src_o  out  32/32/4/1/1  shared target bus; combinational copies of h_*
im_re_o, im_we_o, dm_re_o, dm_we_o, io_re_o, io_we_o  out  1 each  per-target strobes
im_rdata_i, dm_rdata_i, io_rdata_i  in  32 each  target read data
im_ack_i, dm_ack_i, io_ack_i, im_err_i, dm_err_i, io_err_i  in  1 each  target responses
busy_o  out  1  access outstanding (state != IDLE)
tmo_o  out  1  single-cycle pulse when an access times out

Behaviour:
- Reset: state IDLE, selection NONE, counter 0. All outputs 0 except t_* buses, which stay combinational copies.
- Decode is combinational on h_addr_i. A region is hit when (h_addr_i & ~(SIZE-1)) == BASE. On overlap, priority is IO > DMEM > IMEM.
- FSM states: IDLE, BUSY, ERR.
- IDLE, on h_re_i or h_we_i:
  - Valid hit (IO additionally requires h_priv_i=1): assert the matching target strobe in the same cycle (zero latency). Latch the selection, clear the counter, go to BUSY.
  - Miss or user-mode IO: drive no target strobe and go to ERR.
  - If h_re_i and h_we_i are both high, both strobes are forwarded.
- BUSY:
  - Forward only the selected target's ack/err/rdata; responses from non-selected targets are ignored.
  - ack alone: h_ack_o=1 and h_rdata_o=selected rdata that same cycle; go to IDLE.
  - err (with or without ack): h_err_o=1, h_ack_o=0, h_rdata_o=0; go to IDLE.
  - No response: counter increments each cycle. Once TMO_CYCLES BUSY cycles elapse without a response, go to ERR with tmo_o=1 in the ERR cycle.
  - Strobes arriving during BUSY are protocol violations: not forwarded, no effect.
- ERR: h_err_o=1 for exactly one cycle, then IDLE. Strobes in this cycle are ignored.
- Target responses in IDLE or ERR are ignored, including a late ack after a timeout. Targets must respond at least 1 cycle after their strobe.
- Timing: request at cycle c0 → earliest h_ack_o at c0+1. Responses are accepted through c0+TMO_CYCLES; timeout error appears at c0+TMO_CYCLES+1. Unmapped error appears at c0+1.
- Counter width is 10 bits; it saturates and never wraps.
- Reset asserted mid-access: immediate return to IDLE, pending response discarded, no ack/err generated.

Test Plan:
- Read 0x00000010 with im_ack_i=1 and im_rdata_i=0xDEADBEEF one cycle after im_re_o → h_ack_o=1 and h_rdata_o=0xDEADBEEF at c0+1; no dm/io strobes at any point.
- Write 0x80000004, ben=4'b0011 → dm_we_o at c0 with t_ben_o=4'b0011; dm_ack_i at c0+3 → h_ack_o at c0+3, busy_o high for c1..c3.
- Read 0x40000000 (unmapped) → no target strobes, h_err_o=1 at c0+1, h_ack_o=0, busy_o=1 for one cycle.
- Write 0xFFFFFE08 with h_priv_i=0 → no io_we_o, h_err_o at c0+1. Same access with h_priv_i=1 → io_we_o at c0.
- Read DMEM with no response, TMO_CYCLES=255 → h_err_o and tmo_o at c0+256. A dm_ack_i at c0+260 is ignored; the next access proceeds normally.
- im_ack_i and im_err_i asserted together → h_err_o=1, h_ack_o=0. Also: dm_ack_i pulsed while IMEM is selected → ignored. Also: rstn_i low during BUSY → outputs 0, state IDLE, no response emitted.
